// File: rtl/fb_tile_blitter_pkg.sv
// Shared draw package: screen/tile geometry defaults, pixel and address
// types, and the blitter FSM state encoding.
package fb_tile_blitter_pkg;

  // Geometry defaults used as parameter defaults by the blitter and the
  // address calculator.
  localparam int unsigned SCREEN_W_DEF   = 640;
  localparam int unsigned SCREEN_H_DEF   = 480;
  localparam int unsigned TILE_WIDTH_DEF = 32;

  // Bus and datapath widths.
  localparam int unsigned COLOR_W    = 8;
  localparam int unsigned FB_ADDR_W  = 21;
  localparam int unsigned ROM_ADDR_W = 18;
  localparam int unsigned TILE_ID_W  = 8;
  localparam int unsigned COORD_W    = 10;
  // One extra bit over COORD_W so DstX+col cannot wrap before clipping.
  localparam int unsigned PIX_W      = 11;

  typedef logic [COLOR_W-1:0]    color_t;
  typedef logic [FB_ADDR_W-1:0]  fb_addr_t;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
  typedef logic [TILE_ID_W-1:0]  tile_id_t;
  typedef logic [COORD_W-1:0]    coord_t;
  typedef logic [PIX_W-1:0]      pix_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/fb_tile_blitter_if.sv
// Blitter bus bundle: request fields, tile ROM read port, frame-buffer write
// port and status.
//   slave  : blitter view (requests/ROM data/FB ready in, addresses/data/status out)
//   master : requester + memory side view
interface fb_tile_blitter_if;
  import fb_tile_blitter_pkg::*;

  // Request
  logic      START;
  tile_id_t  TileId;
  coord_t    DstX;
  coord_t    DstY;
  logic      KeyEn;
  color_t    KeyColor;
  // Tile ROM
  rom_addr_t ROM_ADDR;
  color_t    ROM_DATA;
  // Frame buffer
  fb_addr_t  FB_ADDR;
  color_t    FB_DOUT;
  logic      FB_WE;
  logic      FB_READY;
  // Status
  logic      BUSY;
  logic      DONE;

  modport slave (
    input  START, TileId, DstX, DstY, KeyEn, KeyColor, ROM_DATA, FB_READY,
    output ROM_ADDR, FB_ADDR, FB_DOUT, FB_WE, BUSY, DONE
  );

  modport master (
    output START, TileId, DstX, DstY, KeyEn, KeyColor, ROM_DATA, FB_READY,
    input  ROM_ADDR, FB_ADDR, FB_DOUT, FB_WE, BUSY, DONE
  );

endinterface

// File: rtl/fb_tile_blitter_addr_calc.sv
// Combinational screen (x,y) to frame-buffer address mapping with clip flag.
// Shared between the blitter write path and reader-side address logic.
//   x_i, y_i  : pixel coordinates, 11 bits so off-screen values are visible
//   addr_c_o  : BASE_ADDR + y*SCREEN_W + x, full 21-bit result
//   clip_c_o  : 1 when the pixel lies outside the visible screen
module fb_addr_calc
  import fb_tile_blitter_pkg::*;
#(
  parameter fb_addr_t    BASE_ADDR = '0,
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF
) (
  input  pix_t     x_i,
  input  pix_t     y_i,
  output fb_addr_t addr_c_o,
  output logic     clip_c_o
);

  // Operands widened to the full address width before multiplying.
  assign addr_c_o = BASE_ADDR
                  + FB_ADDR_W'(y_i) * FB_ADDR_W'(SCREEN_W)
                  + FB_ADDR_W'(x_i);

  assign clip_c_o = (x_i >= PIX_W'(SCREEN_W)) || (y_i >= PIX_W'(SCREEN_H));

endmodule

// File: rtl/fb_tile_blitter.sv
// Tile blitter: copies one TILE_WIDTH x TILE_WIDTH tile from the tile ROM into
// the frame buffer at (DstX,DstY), row-major, skipping transparent and
// off-screen pixels. Each pixel takes a FETCH cycle (ROM address out) and at
// least one WRITE cycle (FB write held until FB_READY).
//   CLK, RESET_H : clock, synchronous active-high reset
//   bus (slave)  : START/TileId/DstX/DstY/KeyEn/KeyColor request,
//                  ROM_ADDR/ROM_DATA tile ROM port,
//                  FB_ADDR/FB_DOUT/FB_WE/FB_READY frame-buffer write port,
//                  BUSY/DONE status
module fb_tile_blitter
  import fb_tile_blitter_pkg::*;
#(
  parameter fb_addr_t    FRAME_BUFFER_ADDR = '0,
  parameter int unsigned TILE_WIDTH        = TILE_WIDTH_DEF,
  parameter int unsigned SCREEN_W          = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H          = SCREEN_H_DEF
) (
  input logic              CLK,
  input logic              RESET_H,
  fb_tile_blitter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TILE_WIDTH);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = CNT_W'(TILE_WIDTH - 1);

  // Tile ROM address of pixel (row,col) of a tile.
  function automatic rom_addr_t tile_rom_addr(input tile_id_t tile,
                                              input cnt_t     row,
                                              input cnt_t     col);
    return ROM_ADDR_W'(tile) * ROM_ADDR_W'(TILE_WIDTH * TILE_WIDTH)
         + ROM_ADDR_W'(row) * ROM_ADDR_W'(TILE_WIDTH)
         + ROM_ADDR_W'(col);
  endfunction

  state_e    state_q;
  tile_id_t  tile_q;
  coord_t    dst_x_q;
  coord_t    dst_y_q;
  logic      key_en_q;
  color_t    key_color_q;
  cnt_t      row_q;
  cnt_t      col_q;
  rom_addr_t rom_addr_q;
  fb_addr_t  fb_addr_q;
  color_t    fb_dout_q;
  logic      fb_we_q;
  logic      busy_q;
  logic      done_q;

  pix_t      pix_x_c;
  pix_t      pix_y_c;
  fb_addr_t  pix_addr_c;
  logic      pix_clip_c;
  logic      key_hit_c;
  logic      last_px_c;
  cnt_t      col_d;
  cnt_t      row_d;

  // Destination pixel of the current (row,col).
  assign pix_x_c = pix_t'(dst_x_q) + pix_t'(col_q);
  assign pix_y_c = pix_t'(dst_y_q) + pix_t'(row_q);

  fb_addr_calc #(
    .BASE_ADDR (FRAME_BUFFER_ADDR),
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H)
  ) u_addr_calc (
    .x_i      (pix_x_c),
    .y_i      (pix_y_c),
    .addr_c_o (pix_addr_c),
    .clip_c_o (pix_clip_c)
  );

  // ROM_DATA belongs to the address presented during FETCH.
  assign key_hit_c = key_en_q && (bus.ROM_DATA == key_color_q);

  // Row-major advance; col wraps naturally because TILE_WIDTH is a power of two.
  assign last_px_c = (row_q == CNT_MAX) && (col_q == CNT_MAX);
  assign col_d     = col_q + CNT_W'(1);
  assign row_d     = (col_q == CNT_MAX) ? row_q + CNT_W'(1) : row_q;

  // Blit sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET_H) begin
      state_q     <= ST_IDLE;
      tile_q      <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      key_en_q    <= 1'b0;
      key_color_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rom_addr_q  <= '0;
      fb_addr_q   <= '0;
      fb_dout_q   <= '0;
      fb_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            tile_q      <= bus.TileId;
            dst_x_q     <= bus.DstX;
            dst_y_q     <= bus.DstY;
            key_en_q    <= bus.KeyEn;
            key_color_q <= bus.KeyColor;
            row_q       <= '0;
            col_q       <= '0;
            rom_addr_q  <= tile_rom_addr(bus.TileId, '0, '0);
            busy_q      <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end

        // Capture pixel, target address and write/skip decision together.
        ST_FETCH: begin
          fb_addr_q <= pix_addr_c;
          fb_dout_q <= bus.ROM_DATA;
          fb_we_q   <= !(pix_clip_c || key_hit_c);
          state_q   <= ST_WRITE;
        end

        // A skipped pixel (FB_WE low) advances at once; a written one waits
        // for FB_READY with address and data held.
        ST_WRITE: begin
          if (!fb_we_q || bus.FB_READY) begin
            fb_we_q <= 1'b0;
            if (last_px_c) begin
              state_q <= ST_FINISH;
            end else begin
              col_q      <= col_d;
              row_q      <= row_d;
              rom_addr_q <= tile_rom_addr(tile_q, row_d, col_d);
              state_q    <= ST_FETCH;
            end
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          row_q   <= '0;
          col_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ROM_ADDR = rom_addr_q;
  assign bus.FB_ADDR  = fb_addr_q;
  assign bus.FB_DOUT  = fb_dout_q;
  assign bus.FB_WE    = fb_we_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_fb_tile_blitter.sv
// Directed testbench for fb_tile_blitter: behavioural tile ROM, frame-buffer
// write monitor with duplicate/order/stall/content tracking, and a linear
// sequence of blit scenarios checked with immediate assertions.
module tb_fb_tile_blitter;
  import fb_tile_blitter_pkg::*;

  localparam int unsigned TW = 32;
  localparam int unsigned SW = 640;
  localparam int unsigned SH = 480;

  logic CLK;
  logic RESET_H;

  fb_tile_blitter_if bus();

  fb_tile_blitter dut (
    .CLK     (CLK),
    .RESET_H (RESET_H),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected request parameters of the blit in flight.
  logic [7:0]  exp_tile = 8'd0;
  int unsigned exp_dx   = 0;
  int unsigned exp_dy   = 0;
  bit          exp_ken  = 1'b0;
  logic [7:0]  exp_kc   = 8'd0;

  bit ready_mode = 1'b0;
  bit clr_mon    = 1'b0;

  // Monitor state.
  logic [7:0]  fb_mem  [int unsigned];
  logic [7:0]  ref_img [int unsigned];
  int          wr_cnt, dup_cnt, bad_cnt, zero_cnt, order_err;
  int          stall_err, stall_cnt, done_cnt, done_busy_err;
  int unsigned last_addr;
  int unsigned first_addr;
  bit          have_last;
  bit          prev_stall;
  logic [20:0] prev_addr;
  logic [7:0]  prev_dout;

  // Tile ROM contents: tile 1 has colour 00 on every odd column, all other
  // pixels are nonzero.
  function automatic logic [7:0] rom_f(input logic [17:0] a);
    logic [7:0] v;
    if (a[17:10] == 8'd1 && a[0]) return 8'h00;
    v = a[7:0] + (a[17:10] * 8'd37) + {3'b000, a[9:5]};
    if (v == 8'h00) v = 8'hA5;
    return v;
  endfunction

  // True when a write of d to addr belongs to the described blit.
  function automatic bit pixel_ok(input int unsigned addr, input logic [7:0] d,
                                  input logic [7:0] t, input int unsigned dx,
                                  input int unsigned dy, input bit ken,
                                  input logic [7:0] kc);
    int unsigned x, y, c, r;
    x = addr % SW;
    y = addr / SW;
    if (x < dx || y < dy || y >= SH) return 1'b0;
    c = x - dx;
    r = y - dy;
    if (c >= TW || r >= TW) return 1'b0;
    if (ken && d == kc) return 1'b0;
    return d == rom_f({t, 5'(r), 5'(c)});
  endfunction

  assign bus.ROM_DATA = rom_f(bus.ROM_ADDR);

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  // FB_READY: always high, or high one cycle in three.
  initial begin
    int rc;
    rc = 0;
    bus.FB_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (ready_mode) begin
        rc = (rc == 2) ? 0 : rc + 1;
        bus.FB_READY = (rc == 0);
      end else begin
        bus.FB_READY = 1'b1;
      end
    end
  end

  // Write-port monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (clr_mon) begin
        fb_mem.delete();
        wr_cnt = 0; dup_cnt = 0; bad_cnt = 0; zero_cnt = 0; order_err = 0;
        stall_err = 0; stall_cnt = 0; done_cnt = 0; done_busy_err = 0;
        last_addr = 0; first_addr = 0; have_last = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!bus.FB_WE || bus.FB_ADDR !== prev_addr ||
                           bus.FB_DOUT !== prev_dout))
          stall_err++;
        prev_stall = bus.FB_WE && !bus.FB_READY;
        prev_addr  = bus.FB_ADDR;
        prev_dout  = bus.FB_DOUT;
        if (bus.FB_WE && !bus.FB_READY) stall_cnt++;
        if (bus.FB_WE && bus.FB_READY) begin
          if (fb_mem.exists(32'(bus.FB_ADDR))) dup_cnt++;
          fb_mem[32'(bus.FB_ADDR)] = bus.FB_DOUT;
          if (have_last && 32'(bus.FB_ADDR) <= last_addr) order_err++;
          if (!have_last) first_addr = 32'(bus.FB_ADDR);
          last_addr = 32'(bus.FB_ADDR);
          have_last = 1'b1;
          wr_cnt++;
          if (bus.FB_DOUT == 8'h00) zero_cnt++;
          if (!pixel_ok(32'(bus.FB_ADDR), bus.FB_DOUT, exp_tile, exp_dx, exp_dy,
                        exp_ken, exp_kc))
            bad_cnt++;
        end
        if (bus.DONE) begin
          done_cnt++;
          if (bus.BUSY) done_busy_err++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge CLK);
    #1;
    clr_mon = 1'b0;
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic launch(input logic [7:0] t, input int unsigned dx, input int unsigned dy,
                        input bit ken, input logic [7:0] kc);
    @(negedge CLK);
    exp_tile = t; exp_dx = dx; exp_dy = dy; exp_ken = ken; exp_kc = kc;
    RESET_H      = 1'b0;
    bus.START    = 1'b1;
    bus.TileId   = t;
    bus.DstX     = 10'(dx);
    bus.DstY     = 10'(dy);
    bus.KeyEn    = ken;
    bus.KeyColor = kc;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  // Wait for DONE (bounded); check latency when exp_lat is nonzero, BUSY
  // low alongside DONE, and DONE lasting one cycle.
  task automatic finish_blit(input string tag, input int limit, input int exp_lat);
    int n;
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) begin
        n = i;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(n != 0), 32'd1);
    if (exp_lat != 0) check({tag, "_done_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(bus.BUSY), 32'd0);
    @(posedge CLK);
    #1;
    check({tag, "_done_one_cycle"}, 32'(bus.DONE), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_busy_overlap"}, 32'(done_busy_err), 32'd0);
  endtask

  initial begin
    int mism;
    RESET_H      = 1'b1;
    bus.START    = 1'b0;
    bus.TileId   = '0;
    bus.DstX     = '0;
    bus.DstY     = '0;
    bus.KeyEn    = 1'b0;
    bus.KeyColor = '0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_fb_we", 32'(bus.FB_WE), 32'd0);
    check("rst_fb_addr", 32'(bus.FB_ADDR), 32'd0);
    check("rst_fb_dout", 32'(bus.FB_DOUT), 32'd0);
    check("rst_rom_addr", 32'(bus.ROM_ADDR), 32'd0);

    // Scenario 1: tile 0 at (0,0), START presented as reset falls.
    clear_mon();
    launch(8'd0, 0, 0, 1'b0, 8'h00);
    check("s1_busy_after_start", 32'(bus.BUSY), 32'd1);
    finish_blit("s1", 3000, 2049);
    check("s1_writes", 32'(wr_cnt), 32'd1024);
    check("s1_bad_data", 32'(bad_cnt), 32'd0);
    check("s1_dups", 32'(dup_cnt), 32'd0);
    check("s1_order", 32'(order_err), 32'd0);
    check("s1_first_addr", first_addr, 32'd0);
    check("s1_last_addr", last_addr, 32'd19871);
    ref_img = fb_mem;

    // Scenario 2: colour key 00 on tile 1 drops every odd column.
    clear_mon();
    launch(8'd1, 100, 50, 1'b1, 8'h00);
    finish_blit("s2", 3000, 2049);
    check("s2_writes", 32'(wr_cnt), 32'd512);
    check("s2_zero_data", 32'(zero_cnt), 32'd0);
    check("s2_bad_data", 32'(bad_cnt), 32'd0);

    // Scenario 3: bottom-right corner clipping.
    clear_mon();
    launch(8'd2, 624, 464, 1'b0, 8'h00);
    finish_blit("s3", 3000, 2049);
    check("s3_writes", 32'(wr_cnt), 32'd256);
    check("s3_last_addr", last_addr, 32'd307199);
    check("s3_bad_data", 32'(bad_cnt), 32'd0);

    // Scenario 4: FB_READY one cycle in three; image must equal scenario 1.
    ready_mode = 1'b1;
    clear_mon();
    launch(8'd0, 0, 0, 1'b0, 8'h00);
    finish_blit("s4", 8000, 0);
    ready_mode = 1'b0;
    check("s4_stalls_seen", 32'(stall_cnt > 0), 32'd1);
    check("s4_stall_stable", 32'(stall_err), 32'd0);
    check("s4_dups", 32'(dup_cnt), 32'd0);
    check("s4_writes", 32'(wr_cnt), 32'd1024);
    mism = 0;
    foreach (ref_img[k])
      if (!fb_mem.exists(k) || fb_mem[k] !== ref_img[k]) mism++;
    check("s4_image_mismatch", 32'(mism), 32'd0);
    check("s4_image_size", 32'(fb_mem.num()), 32'd1024);

    // Scenario 5: reset at pixel 100, then a fresh blit.
    clear_mon();
    launch(8'd0, 0, 0, 1'b0, 8'h00);
    for (int i = 0; i < 1000 && wr_cnt < 100; i++) begin
      @(posedge CLK);
      #1;
    end
    check("s5_reached_px100", 32'(wr_cnt), 32'd100);
    @(negedge CLK);
    RESET_H = 1'b1;
    @(posedge CLK);
    #1;
    check("s5_rst_busy", 32'(bus.BUSY), 32'd0);
    check("s5_rst_fb_we", 32'(bus.FB_WE), 32'd0);
    check("s5_rst_fb_addr", 32'(bus.FB_ADDR), 32'd0);
    check("s5_rst_rom_addr", 32'(bus.ROM_ADDR), 32'd0);
    @(negedge CLK);
    RESET_H = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    check("s5_no_done", 32'(done_cnt), 32'd0);
    check("s5_not_resumed_busy", 32'(bus.BUSY), 32'd0);
    check("s5_not_resumed_writes", 32'(wr_cnt), 32'd100);
    clear_mon();
    launch(8'd3, 10, 20, 1'b0, 8'h00);
    finish_blit("s5b", 3000, 2049);
    check("s5b_writes", 32'(wr_cnt), 32'd1024);
    check("s5b_bad_data", 32'(bad_cnt), 32'd0);

    // Scenario 6: START re-pulsed with TileId 5 while busy.
    clear_mon();
    launch(8'd4, 300, 200, 1'b0, 8'h00);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.TileId = 8'd5;
    bus.DstX   = 10'd0;
    bus.DstY   = 10'd0;
    @(negedge CLK);
    bus.START = 1'b0;
    finish_blit("s6", 3000, 0);
    check("s6_writes", 32'(wr_cnt), 32'd1024);
    check("s6_bad_data", 32'(bad_cnt), 32'd0);
    repeat (5) @(posedge CLK);
    #1;
    check("s6_no_requeue", 32'(bus.BUSY), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_tile_blitter.md
FB_TILE_BLITTER -- requirements
Module: fb_tile_blitter

Interface
REQ-001 Parameter FRAME_BUFFER_ADDR, 21'b0, base address of frame buffer.
REQ-002 Parameter TILE_WIDTH, 32, tile edge in pixels (power of two).
REQ-003 Parameter SCREEN_W, 640, visible width in pixels.
REQ-004 Parameter SCREEN_H, 480, visible height in pixels.
REQ-005 CLK  in  1  system clock (50 MHz); the only clock.
REQ-006 RESET_H  in  1  synchronous, active-high reset.
REQ-007 START  in  1  blit request, sampled only in IDLE.
REQ-008 TileId  in  8  source tile index.
REQ-009 DstX, DstY  in  10 each  top-left destination pixel.
REQ-010 KeyEn  in  1  transparency enable; KeyColor  in  8  transparent colour ID.
REQ-011 ROM_ADDR  out  18  tile ROM address; ROM_DATA  in  8  colour ID, valid 1 cycle after ROM_ADDR.
REQ-012 FB_ADDR  out  21; FB_DOUT  out  8; FB_WE  out  1  frame-buffer write port.
REQ-013 FB_READY  in  1  write accepted in any cycle where FB_WE=1 and FB_READY=1.
REQ-014 BUSY  out  1  high from the cycle after an accepted START until DONE; DONE  out  1  single-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, FETCH, WRITE, FINISH.
REQ-016 IDLE: START=1 latches TileId, DstX, DstY, KeyEn, KeyColor, clears the row/column counters and moves to FETCH; inputs are ignored until the next IDLE.
REQ-017 FETCH: drive ROM_ADDR = TileId*TILE_WIDTH*TILE_WIDTH + row*TILE_WIDTH + col, then go to WRITE.
REQ-018 WRITE: FB_DOUT = ROM_DATA (registered on entry); FB_ADDR = FRAME_BUFFER_ADDR + (DstY+row)*SCREEN_W + (DstX+col), computed at 21 bits with no truncation.
REQ-019 Skip condition: KeyEn=1 and pixel==KeyColor, or DstX+col >= SCREEN_W, or DstY+row >= SCREEN_H (11-bit compare).
REQ-020 For a skipped pixel, FB_WE stays 0 and the pixel advances in 1 cycle.
REQ-021 For a written pixel, FB_WE=1 and FB_ADDR/FB_DOUT are held stable until FB_READY=1; the pixel advances in the cycle of acceptance.
REQ-022 Advance: col increments; when col wraps at TILE_WIDTH-1, col=0 and row increments; after the last pixel (row=col=TILE_WIDTH-1) go to FINISH, otherwise go to FETCH.
REQ-023 FINISH: DONE=1 for exactly one cycle, then go to IDLE; BUSY=0 in the same cycle as DONE.
REQ-024 Pixel order is row-major, top to bottom and left to right; each accepted FB address is written exactly once.
REQ-025 Latency with FB_READY held high: 2 cycles per pixel, so DONE asserts 2*TILE_WIDTH^2 + 1 cycles after the accepting START edge.
REQ-026 START=1 during BUSY is ignored; the new request is not queued.
REQ-027 FB_WE is never 1 outside WRITE.

Reset
REQ-028 RESET_H=1 at any clock edge, including mid-blit, forces: state IDLE, BUSY=0, DONE=0, FB_WE=0, FB_ADDR=0, FB_DOUT=0, ROM_ADDR=0, counters 0.
REQ-029 An interrupted blit is abandoned and is not resumed.
REQ-030 The first START is accepted on the first clock after RESET_H falls.

Structure
REQ-031 A shared draw package holds SCREEN_W/SCREEN_H, TILE_WIDTH, the colour-ID typedef (8 bits), the FB address typedef (21 bits) and the FSM state enum.
REQ-032 A single sub-module, fb_addr_calc, is allowed: combinational (x,y) -> FB address plus clip flag, shared with reader-side address logic.

Verification
REQ-033 Scenario 1: TileId=0, Dst=(0,0), KeyEn=0, FB_READY=1 -> 1024 writes to addresses 0..31 of each row (row r at r*640), data equal to the ROM contents, DONE at cycle 2049.
REQ-034 Scenario 2: KeyEn=1, KeyColor=8'h00, tile whose odd columns are 00 -> exactly 512 writes, none with data 00.
REQ-035 Scenario 3: Dst=(624,464) -> only cols 0..15 and rows 0..15 are written (256 writes); last address = 479*640+639; DONE still pulses.
REQ-036 Scenario 4: FB_READY toggles 1-of-3 cycles -> FB_ADDR and FB_DOUT are stable while stalled, no write is lost or duplicated, and the final memory image equals Scenario 1.
REQ-037 Scenario 5: RESET_H asserted at pixel 100 -> next cycle BUSY=0 and FB_WE=0; no DONE pulse; a fresh START completes normally.
REQ-038 Scenario 6: START re-pulsed during BUSY with TileId=5 -> ignored; all writes use the original TileId.
